iir_mac_sequencer: RTL and testbench

Time-multiplexed IIR filter engine: one shared multiply-accumulate unit is stepped through the b/a taps of a direct-form-I filter, one product per cycle, instead of instantiating a multiplier per tap. It sits in the preprocessing chain ahead of the effect stages, consuming one 16-bit Q4.12 sample per handshake and emitting one filtered sample. Coefficients are run-time loadable through a shadow bank with an atomic commit, so the chain can be retuned without glitching a sample mid-computation.

---
 rtl/fxp_pkg.sv | 30 +++
 rtl/fxp_mac.sv | 34 +++
 rtl/iir_mac_sequencer.sv | 135 +++++++++++++
 tb/tb_iir_mac_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Fixed-point constants, sequencer state encoding and output saturation
// shared by the IIR MAC sequencer and its multiply-accumulate unit.
// Contents: FXP_SIZE/FXP_FRAC/COMP_SIZE defaults, state_t, saturate().
package fxp_pkg;

   localparam int FXP_SIZE  = 16;
   localparam int FXP_FRAC  = 12;
   localparam int COMP_SIZE = FXP_SIZE + FXP_FRAC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      WB   = 2'd2
   } state_t;

   // Clip a COMP_SIZE-wide result into the FXP_SIZE-wide output range.
   function automatic logic signed [FXP_SIZE-1:0] saturate(input logic signed [COMP_SIZE-1:0] v);
      logic signed [COMP_SIZE-1:0] hi;
      logic signed [COMP_SIZE-1:0] lo;
      hi = COMP_SIZE'((2 ** (FXP_SIZE - 1)) - 1);
      lo = -hi - 1;
      if (v > hi)
         return hi[FXP_SIZE-1:0];
      else if (v < lo)
         return lo[FXP_SIZE-1:0];
      else
         return v[FXP_SIZE-1:0];
   endfunction

endpackage

// File: rtl/fxp_mac.sv
// Shared signed multiply-accumulate unit stepped by the sequencer FSM.
// Latency: product lands in the accumulator on the edge i_en is high.
// Backpressure: none; the FSM owns i_en/i_clear/i_sub and operand selection.
// Ports: clk, rst (sync, active-high), i_clear, i_en, i_sub, i_coef, i_hist, o_acc.
module fxp_mac #(
   parameter int OP_W  = 28,
   parameter int ACC_W = 2 * OP_W + 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_en,
   input  logic                    i_sub,
   input  logic signed [OP_W-1:0]  i_coef,
   input  logic signed [OP_W-1:0]  i_hist,
   output logic signed [ACC_W-1:0] o_acc
);

   logic signed [2*OP_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [ACC_W-1:0]   r_acc;

   assign w_prod     = i_coef * i_hist;
   assign w_prod_ext = {{(ACC_W - 2*OP_W){w_prod[2*OP_W-1]}}, w_prod};
   assign o_acc      = r_acc;

   always_ff @(posedge clk) begin
      if (rst || i_clear)
         r_acc <= '0;
      else if (i_en)
         r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
   end

endmodule

// File: rtl/iir_mac_sequencer.sv
// Direct-form-I IIR filter time-multiplexed over one MAC, with a shadow coefficient bank.
// Latency: o_valid 2*ORDER+2 cycles after accept; one sample per 2*ORDER+3 cycles max.
// Backpressure: i_ready only in IDLE; a held i_valid is accepted on the next IDLE cycle.
// Ports: clk, rst, i_valid/i_ready/i_sample, o_valid/o_sample, cfg_we/cfg_addr/cfg_data,
//        cfg_commit, cfg_pending.
module iir_mac_sequencer
   import fxp_pkg::*;
#(
   parameter int ORDER = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_valid,
   output logic                        i_ready,
   input  logic signed [FXP_SIZE-1:0]  i_sample,
   output logic                        o_valid,
   output logic signed [FXP_SIZE-1:0]  o_sample,
   input  logic                        cfg_we,
   input  logic [4:0]                  cfg_addr,
   input  logic signed [COMP_SIZE-1:0] cfg_data,
   input  logic                        cfg_commit,
   output logic                        cfg_pending
);

   localparam int NTAP  = 2 * ORDER + 1;
   localparam int ACC_W = 2 * COMP_SIZE + 4;
   localparam int K_W   = $clog2(NTAP);

   state_t                       r_state;
   logic [K_W-1:0]               r_k;
   logic                         r_pending;
   logic                         r_o_valid;
   logic signed [FXP_SIZE-1:0]   r_o_sample;
   logic signed [COMP_SIZE-1:0]  r_coef_act [NTAP];
   logic signed [COMP_SIZE-1:0]  r_coef_shd [NTAP];
   logic signed [COMP_SIZE-1:0]  r_x [ORDER+1];
   logic signed [COMP_SIZE-1:0]  r_y [ORDER];

   logic                         w_accept;
   logic                         w_commit;
   logic                         w_sub;
   logic signed [COMP_SIZE-1:0]  w_coef;
   logic signed [COMP_SIZE-1:0]  w_hist;
   logic signed [COMP_SIZE-1:0]  w_x_in;
   logic signed [COMP_SIZE-1:0]  w_r;
   logic signed [ACC_W-1:0]      w_acc;

   assign i_ready     = (r_state == IDLE) && !rst;
   assign w_accept    = i_valid && i_ready;
   // Copy only on an idle cycle with no accept so the active bank is stable for a whole sample.
   assign w_commit    = r_pending && (r_state == IDLE) && !w_accept;
   assign w_sub       = int'(r_k) > ORDER;
   assign w_x_in      = {{(COMP_SIZE - FXP_SIZE){i_sample[FXP_SIZE-1]}}, i_sample};
   assign w_r         = COMP_SIZE'(w_acc >>> FXP_FRAC);
   assign o_valid     = r_o_valid;
   assign o_sample    = r_o_sample;
   assign cfg_pending = r_pending;

   // Operand muxes: taps 0..ORDER pair b_k with x_k, the rest pair a_j with y_(j-1).
   always_comb begin
      w_coef = '0;
      w_hist = '0;
      for (int i = 0; i < NTAP; i++)
         if (int'(r_k) == i) w_coef = r_coef_act[i];
      for (int i = 0; i <= ORDER; i++)
         if (int'(r_k) == i) w_hist = r_x[i];
      for (int j = 1; j <= ORDER; j++)
         if (int'(r_k) == ORDER + j) w_hist = r_y[j-1];
   end

   fxp_mac #(
      .OP_W  (COMP_SIZE),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_accept),
      .i_en    (r_state == MAC),
      .i_sub   (w_sub),
      .i_coef  (w_coef),
      .i_hist  (w_hist),
      .o_acc   (w_acc)
   );

   // Shadow bank is writable at any time; out-of-range addresses fall through.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAP; i++) r_coef_shd[i] <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < NTAP; i++)
            if (int'(cfg_addr) == i) r_coef_shd[i] <= cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_k        <= '0;
         r_pending  <= 1'b0;
         r_o_valid  <= 1'b0;
         r_o_sample <= '0;
         for (int i = 0; i < NTAP; i++) r_coef_act[i] <= '0;
         for (int i = 0; i <= ORDER; i++) r_x[i] <= '0;
         for (int i = 0; i < ORDER; i++) r_y[i] <= '0;
      end else begin
         r_o_valid <= 1'b0;
         r_pending <= (r_pending && !w_commit) || cfg_commit;
         if (w_commit) r_coef_act <= r_coef_shd;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x[0]  <= w_x_in;
                  r_k     <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               if (int'(r_k) == NTAP - 1) r_state <= WB;
               else                       r_k     <= r_k + 1'b1;
            end
            WB: begin
               // Histories keep the unsaturated result; only the port is clipped.
               for (int i = ORDER; i >= 1; i--) r_x[i] <= r_x[i-1];
               for (int i = ORDER - 1; i >= 1; i--) r_y[i] <= r_y[i-1];
               r_y[0]     <= w_r;
               r_o_valid  <= 1'b1;
               r_o_sample <= saturate(w_r);
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
module tb_iir_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [15:0] i_sample;
   logic        o_valid;
   logic [15:0] o_sample;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [27:0] cfg_data;
   logic        cfg_commit;
   logic        cfg_pending;

   int errors = 0;
   int checks = 0;

   // Reference model: coefficient banks and past inputs/outputs (x_1..x_4, y_0..y_3).
   longint m_shd [9];
   longint m_act [9];
   longint m_xp  [4];
   longint m_yp  [4];

   iir_mac_sequencer #(.ORDER(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .i_ready     (i_ready),
      .i_sample    (i_sample),
      .o_valid     (o_valid),
      .o_sample    (o_sample),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_commit  (cfg_commit),
      .cfg_pending (cfg_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 9; i++) begin m_shd[i] = 0; m_act[i] = 0; end
      for (int i = 0; i < 4; i++) begin m_xp[i] = 0; m_yp[i] = 0; end
   endtask

   // y = sum b_k x_k - sum a_j y_(j-1), scaled by 2^-12, wrapped to 28 bits, clipped to 16.
   task automatic model_step(input logic signed [15:0] s, output logic signed [15:0] exp);
      longint acc;
      longint r;
      acc = m_act[0] * longint'(s);
      for (int k = 1; k <= 4; k++) acc += m_act[k] * m_xp[k-1];
      for (int j = 1; j <= 4; j++) acc -= m_act[4+j] * m_yp[j-1];
      r = acc >>> 12;
      r = (r <<< 36) >>> 36;
      for (int i = 3; i >= 1; i--) begin m_xp[i] = m_xp[i-1]; m_yp[i] = m_yp[i-1]; end
      m_xp[0] = longint'(s);
      m_yp[0] = r;
      if (r > 32767)       exp = 16'sd32767;
      else if (r < -32768) exp = -16'sd32768;
      else                 exp = r[15:0];
   endtask

   task automatic do_reset();
      rst = 1'b1; i_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
      step();
      step();
      rst = 1'b0;
      model_clear();
   endtask

   task automatic wr(input int addr, input longint val);
      cfg_we = 1'b1; cfg_addr = addr[4:0]; cfg_data = val[27:0];
      step();
      cfg_we = 1'b0;
      if (addr < 9) m_shd[addr] = val;
   endtask

   task automatic commit_idle();
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      checks++;
      if (cfg_pending !== 1'b1) begin errors++; $display("FAIL commit_pending_set: got %b want 1", cfg_pending); end
      step();
      checks++;
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL commit_pending_clear: got %b want 0", cfg_pending); end
      for (int i = 0; i < 9; i++) m_act[i] = m_shd[i];
   endtask

   task automatic send(input logic signed [15:0] s, input logic signed [15:0] exp, input string name);
      int n;
      n = 0;
      while (!i_ready && n < 40) begin step(); n++; end
      i_valid = 1'b1; i_sample = s;
      step();
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 40) begin step(); n++; end
      checks++;
      if (n !== 10) begin errors++; $display("FAIL %s latency: got %0d cycles want 10", name, n); end
      checks++;
      if ($signed(o_sample) !== exp) begin
         errors++; $display("FAIL %s o_sample: got %0d want %0d", name, $signed(o_sample), exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b0; i_sample = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
      step();
      step();
      checks++;
      if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      checks++;
      if (o_sample !== 16'd0) begin errors++; $display("FAIL reset_o_sample: got %0d want 0", o_sample); end
      checks++;
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", cfg_pending); end
      rst = 1'b0;
      #1;
      checks++;
      if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", i_ready); end
      // Commit alongside an accept keeps cfg_pending up into MAC; reset must still clear it.
      i_valid = 1'b1; i_sample = 16'd5; cfg_commit = 1'b1;
      step();
      i_valid = 1'b0; cfg_commit = 1'b0;
      checks++;
      if (cfg_pending !== 1'b1) begin errors++; $display("FAIL pending_during_mac: got %b want 1", cfg_pending); end
      rst = 1'b1;
      step();
      checks++;
      if (cfg_pending !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL reset_clears_pending: got pending=%b o_valid=%b want 0 0", cfg_pending, o_valid);
      end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_identity();
      do_reset();
      wr(0, 4096);
      commit_idle();
      send(16'sd1000, 16'sd1000, "identity");
      step();
      checks++;
      if (o_valid !== 1'b0 || $signed(o_sample) !== 16'sd1000) begin
         errors++; $display("FAIL identity_hold: got o_valid=%b o_sample=%0d want 0 1000", o_valid, $signed(o_sample));
      end
   endtask

   task automatic test_delay();
      do_reset();
      wr(1, 4096);
      commit_idle();
      send(16'sd100, 16'sd0,   "delay0");
      send(16'sd200, 16'sd100, "delay1");
      send(16'sd300, 16'sd200, "delay2");
   endtask

   task automatic test_feedback();
      do_reset();
      wr(0, 4096);
      wr(5, -2048);
      commit_idle();
      send(16'sd4096, 16'sd4096, "feedback0");
      send(16'sd0,    16'sd2048, "feedback1");
      send(16'sd0,    16'sd1024, "feedback2");
      send(16'sd0,    16'sd512,  "feedback3");
   endtask

   task automatic test_saturation();
      do_reset();
      wr(0, 32768);
      commit_idle();
      send(16'sd8000,  16'sd32767,  "sat_pos");
      send(-16'sd8000, -16'sd32768, "sat_neg");
   endtask

   task automatic test_back_to_back();
      logic [15:0] smp [3];
      int acc_cyc [$];
      int out_cyc [$];
      logic [15:0] outs [$];
      int idx;
      smp = '{16'd111, 16'd222, 16'd333};
      do_reset();
      wr(0, 4096);
      commit_idle();
      idx = 0;
      i_valid = 1'b1; i_sample = smp[0];
      for (int c = 0; c < 60; c++) begin
         logic acc_now;
         acc_now = i_valid && i_ready;
         if (acc_now) acc_cyc.push_back(c);
         step();
         if (acc_now) begin
            idx++;
            if (idx < 3) i_sample = smp[idx];
            else         i_valid = 1'b0;
         end
         if (o_valid) begin out_cyc.push_back(c); outs.push_back(o_sample); end
      end
      i_valid = 1'b0;
      checks++;
      if (acc_cyc.size() != 3 || outs.size() != 3) begin
         errors++; $display("FAIL b2b_counts: got accepts=%0d outputs=%0d want 3 3", acc_cyc.size(), outs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs[i] !== smp[i]) begin errors++; $display("FAIL b2b_value%0d: got %0d want %0d", i, outs[i], smp[i]); end
            checks++;
            if (out_cyc[i] != acc_cyc[i] + 10) begin
               errors++; $display("FAIL b2b_latency%0d: got %0d want 10", i, out_cyc[i] - acc_cyc[i]);
            end
            if (i > 0) begin
               checks++;
               if (acc_cyc[i] - acc_cyc[i-1] != 11) begin
                  errors++; $display("FAIL b2b_interval%0d: got %0d want 11", i, acc_cyc[i] - acc_cyc[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_commit_mid_mac();
      int n;
      logic bad;
      do_reset();
      wr(0, 4096);
      commit_idle();
      i_valid = 1'b1; i_sample = 16'd1000;
      step();
      i_valid = 1'b0;
      step();
      wr(0, 8192);
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      bad = 1'b0;
      n = 3;
      while (!o_valid && n < 40) begin
         if (cfg_pending !== 1'b1) bad = 1'b1;
         step();
         n++;
      end
      checks++;
      if (bad || cfg_pending !== 1'b1) begin errors++; $display("FAIL midmac_pending: got cleared during busy want held 1"); end
      checks++;
      if ($signed(o_sample) !== 16'sd1000 || n !== 10) begin
         errors++; $display("FAIL midmac_old_coef: got %0d at %0d cycles want 1000 at 10", $signed(o_sample), n);
      end
      step();
      checks++;
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL midmac_pending_clear: got %b want 0", cfg_pending); end
      send(16'sd1000, 16'sd2000, "midmac_new_coef");
      // A shadow write landing on the copy cycle must not reach the active bank.
      wr(0, 4096);
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      wr(0, 12288);
      checks++;
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL copycycle_pending: got %b want 0", cfg_pending); end
      send(16'sd1000, 16'sd1000, "copycycle_excluded");
      commit_idle();
      send(16'sd1000, 16'sd3000, "copycycle_later");
   endtask

   task automatic test_reset_mid_mac();
      logic bad;
      do_reset();
      wr(0, 4096);
      wr(1, 4096);
      commit_idle();
      send(16'sd700, 16'sd700, "prereset");
      i_valid = 1'b1; i_sample = 16'd300;
      step();
      i_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_clear();
      bad = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (o_valid !== 1'b0) bad = 1'b1;
         step();
      end
      checks++;
      if (bad) begin errors++; $display("FAIL abort_no_valid: got o_valid=1 want 0"); end
      send(16'sd1000, 16'sd0, "zero_coef");
      wr(0, 4096);
      wr(2, 4096);
      commit_idle();
      send(16'sd500, 16'sd500, "zero_history");
   endtask

   task automatic test_random();
      logic signed [15:0] s;
      logic signed [15:0] exp;
      int v;
      do_reset();
      for (int blk = 0; blk < 2; blk++) begin
         for (int i = 0; i < 9; i++) begin
            if (i <= 4) v = int'($urandom_range(0, 32768)) - 16384;
            else        v = int'($urandom_range(0, 4096)) - 2048;
            wr(i, longint'(v));
         end
         wr(int'($urandom_range(9, 31)), 64'd12345);
         commit_idle();
         for (int t = 0; t < 12; t++) begin
            v = int'($urandom_range(0, 65535));
            s = v[15:0];
            model_step(s, exp);
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) step();
            send(s, exp, "random");
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_delay();
      test_feedback();
      test_saturation();
      test_back_to_back();
      test_commit_mid_mac();
      test_reset_mid_mac();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
